ascii_hex_word_parser: RTL and testbench
========================================

// Module: ascii_hex_word_parser
// PURPOSE
//  Inverse of the LCD nibble-to-character path: accepts a byte stream of ASCII characters
//  (UART RX, keypad or host loader) and assembles hexadecimal digits into WORD_W-bit words.
//  Output words feed the instruction/data memory loader and debug register writes.
//  A valid/ready handshake on both sides; malformed input is flagged and the partial word dropped.
// PARAMETERS
//  WORD_W   32  output word width; multiple of 4
//  DIGITS   WORD_W/4 (derived localparam, not overridable)  max hex digits per word
//  ERRCNT_W 8   width of saturating error counter
// PORTS
//  clk          in   1         system clock, all logic on rising edge
//  rst          in   1         synchronous reset, active-high
//  char_valid   in   1         char_data is valid
//  char_data    in   8         ASCII character
//  char_ready   out  1         parser accepts char this cycle (transfer = valid & ready)
//  word_valid   out  1         word_data/word_ndigits valid
//  word_data    out  WORD_W    assembled word, right-aligned, zero-extended
//  word_ndigits out  clog2(DIGITS+1)  number of hex digits in word (1..DIGITS)
//  word_ready   in   1         consumer takes word (transfer = valid & ready)
//  err          out  1         one-cycle pulse: illegal character accepted
//  err_count    out  ERRCNT_W  saturating count of err pulses
// BEHAVIOUR
//  Character classes (accepted only on transfer):
//   HEX  '0'-'9','A'-'F','a'-'f' -> nibble value; SEP  ' ', ',', CR(0x0D), LF(0x0A), TAB(0x09);
//   SKIP '_' -> ignored, no state change; OTHER -> illegal.
//  FSM states: IDLE (0 digits), ACCUM (1..DIGITS-1 digits), EMIT (word held).
//   IDLE : HEX -> acc={0,nib}, cnt=1, ACCUM (or EMIT if DIGITS==1); SEP/SKIP -> stay; OTHER -> err, stay.
//   ACCUM: HEX -> acc={acc[WORD_W-5:0],nib}, cnt+1; on cnt reaching DIGITS -> EMIT.
//          SEP -> EMIT with current acc/cnt; SKIP -> stay; OTHER -> err, acc/cnt cleared, IDLE.
//   EMIT : word_valid=1, char_ready=0; on word_ready -> acc/cnt cleared, IDLE.
//  char_ready = 1 in IDLE/ACCUM, 0 in EMIT (no char accepted while a word is pending).
//  Latency: char completing a word accepted in cycle N -> word_valid high from N+1.
//   word_ready may be high in the same cycle word_valid rises; char_ready returns high cycle after.
//  word_data/word_ndigits registered, stable while word_valid && !word_ready.
//  Digit DIGITS+1 with no separator starts a new word (no error).
//  err: registered, high exactly one cycle after the illegal char transfer; err_count += 1,
//   saturates at all-ones, cleared only by rst.
//  Reset (any cycle, incl. mid-word or during EMIT): state=IDLE, acc=0, cnt=0, word_valid=0,
//   word_data=0, word_ndigits=0, err=0, err_count=0, char_ready=0 during rst then 1.
//  char_valid low: no state change. No combinational path from char_* to word_* or err.
// STRUCTURE
//  Package ascii_pkg: character constants (CH_SP, CH_CR, CH_LF, CH_TAB, CH_COMMA, CH_USCORE),
//   class enum {CLS_HEX, CLS_SEP, CLS_SKIP, CLS_OTHER}, FSM state enum.
//  Sub-module ascii_hex_classify (combinational): char[7:0] -> class, nibble[3:0];
//   reusable by the keypad and monitor paths. Parser top holds FSM, shift accumulator, counters.
// TESTING
//  1 "1234ABCD" back-to-back, word_ready=1 -> one word 0x1234ABCD, ndigits=8, valid cycle after 'D'.
//  2 "ff\n" -> 0x000000FF, ndigits=2; "dead_beef " -> 0xDEADBEEF (underscore ignored, no err).
//  3 "12G5 " -> err pulse after 'G', err_count=1, no word for "12"; then word 0x00000005, ndigits=1.
//  4 "9" then SEP with word_ready=0 for 5 cycles -> word_valid held, data stable, char_ready=0;
//    chars offered meanwhile not consumed; release -> word 0x9 transferred once.
//  5 "123456789" -> word 0x12345678, then "9\n" -> 0x00000009; leading/double separators ",, \r\n" -> no word.
//  6 rst asserted after "AB" and again during EMIT -> all outputs zero, next "7 " -> word 0x7 only;
//    256+ illegal chars -> err_count saturates at 0xFF.

Source files
------------

// File: rtl/ascii_pkg.sv
// Shared ASCII constants and enums for the hex-word parser and its
// character classifier.
package ascii_pkg;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_TAB    = 8'h09;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_USCORE = 8'h5F;

  typedef enum logic [1:0] {CLS_HEX, CLS_SEP, CLS_SKIP, CLS_OTHER} char_cls_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_EMIT} state_t;
endpackage

// File: rtl/ascii_hex_classify.sv
// Combinational ASCII character classifier: hex digit / separator / skip / other,
// plus the nibble value for hex digits.
module ascii_hex_classify
  import ascii_pkg::*;
(
  input  logic [7:0] ch,
  output char_cls_t  cls,
  output logic [3:0] nibble
);
  always_comb begin
    cls    = CLS_OTHER;
    nibble = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      cls    = CLS_HEX;
      nibble = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so value = low nibble + 9
      cls    = CLS_HEX;
      nibble = ch[3:0] + 4'd9;
    end else if (ch == CH_SP || ch == CH_COMMA || ch == CH_CR ||
                 ch == CH_LF || ch == CH_TAB) begin
      cls = CLS_SEP;
    end else if (ch == CH_USCORE) begin
      cls = CLS_SKIP;
    end
  end
endmodule

// File: rtl/ascii_hex_word_parser.sv
// Assembles ASCII hex digits into WORD_W-bit words with valid/ready on both
// sides; illegal characters pulse err and drop the partial word.
module ascii_hex_word_parser
  import ascii_pkg::*;
#(
  parameter  int WORD_W   = 32,
  parameter  int ERRCNT_W = 8,
  localparam int DIGITS   = WORD_W / 4,
  localparam int CNT_W    = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                char_valid,
  input  logic [7:0]          char_data,
  output logic                char_ready,
  output logic                word_valid,
  output logic [WORD_W-1:0]   word_data,
  output logic [CNT_W-1:0]    word_ndigits,
  input  logic                word_ready,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_count
);
  char_cls_t          cls;
  logic [3:0]         nib;
  logic               take;
  state_t             state;
  logic [WORD_W-1:0]  acc;
  logic [CNT_W-1:0]   cnt;

  ascii_hex_classify u_cls (.ch(char_data), .cls(cls), .nibble(nib));

  assign take         = char_valid & char_ready;
  assign word_data    = acc;
  assign word_ndigits = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      cnt        <= '0;
      char_ready <= 1'b0;
      word_valid <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE, ST_ACCUM: begin
          char_ready <= 1'b1;
          if (take) begin
            case (cls)
              CLS_HEX: begin
                acc <= (acc << 4) | WORD_W'(nib);
                cnt <= cnt + 1'b1;
                if (cnt == CNT_W'(DIGITS - 1)) begin
                  state      <= ST_EMIT;
                  char_ready <= 1'b0;
                  word_valid <= 1'b1;
                end else begin
                  state <= ST_ACCUM;
                end
              end
              CLS_SEP: begin
                if (state == ST_ACCUM) begin
                  state      <= ST_EMIT;
                  char_ready <= 1'b0;
                  word_valid <= 1'b1;
                end
              end
              CLS_OTHER: begin
                err <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
                acc   <= '0;
                cnt   <= '0;
                state <= ST_IDLE;
              end
              default: ;
            endcase
          end
        end
        ST_EMIT: begin
          // word held stable until the consumer takes it
          if (word_ready) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            word_valid <= 1'b0;
            char_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascii_hex_word_parser.sv
// Bench for ascii_hex_word_parser: table vectors, hand-written corner
// sequences and random strings checked against a string-level model.
module tb_ascii_hex_word_parser;
  localparam int DIGITS = 8;

  typedef struct { logic [31:0] d; int n; } wrd_t;
  typedef struct {
    string s; int nw; logic [31:0] d0; int n0; logic [31:0] d1; int n1; int ne;
  } vec_t;

  logic        clk, rst;
  logic        char_valid, char_ready;
  logic [7:0]  char_data;
  logic        word_valid, word_ready, err;
  logic [31:0] word_data;
  logic [3:0]  word_ndigits;
  logic [7:0]  err_count;

  logic rnd_ready, rnd_bit, ready_force;
  assign word_ready = rnd_ready ? rnd_bit : ready_force;

  int   nchecks = 0, nerrs = 0, err_seen = 0;
  wrd_t got[$], expq[$];

  ascii_hex_word_parser #(.WORD_W(32), .ERRCNT_W(8)) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .word_valid(word_valid), .word_data(word_data),
    .word_ndigits(word_ndigits), .word_ready(word_ready), .err(err),
    .err_count(err_count));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rnd_bit = 1'b0;
    forever begin
      @(posedge clk); #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // Transfers observed mid-cycle happen at the following rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid && word_ready) got.push_back('{word_data, int'(word_ndigits)});
      if (err) err_seen++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    nchecks++;
    if (act !== exp_v) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic send_char(input byte c);
    int t = 0;
    char_valid = 1'b1;
    char_data  = 8'(c);
    @(negedge clk);
    while (!char_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!char_ready) begin
      nchecks++; nerrs++;
      $display("FAIL send_timeout: char %0h never accepted", c);
    end
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic send_q(input byte q[$]);
    foreach (q[i]) send_char(q[i]);
  endtask

  task automatic send_str(input string s);
    byte q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_q(q);
  endtask

  task automatic drain();
    rnd_ready   = 1'b0;
    ready_force = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic int hexval(input byte c);
    string hx = "0123456789abcdef";
    byte   lc = c;
    if (lc >= "A" && lc <= "F") lc = lc + 8'sd32;
    for (int i = 0; i < 16; i++) if (hx[i] == lc) return i;
    return -1;
  endfunction

  // String-level reference: digits accumulate into a number until a
  // separator, a full word, or an illegal character ends the run.
  task automatic model(input byte q[$], output int ne);
    int          n = 0, k;
    logic [31:0] v = 0;
    ne = 0;
    expq.delete();
    foreach (q[i]) begin
      k = hexval(q[i]);
      if (k >= 0) begin
        v = 32'(v * 16 + 32'(k));
        n++;
        if (n == DIGITS) begin expq.push_back('{v, n}); n = 0; v = 0; end
      end else if (q[i] inside {" ", ",", 8'h0D, 8'h0A, 8'h09}) begin
        if (n > 0) expq.push_back('{v, n});
        n = 0; v = 0;
      end else if (q[i] != "_") begin
        ne++; n = 0; v = 0;
      end
    end
  endtask

  task automatic cmp_words(input string name);
    chk({name, "_count"}, 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      chk({name, "_data"}, 64'(got[i].d), 64'(expq[i].d));
      chk({name, "_ndig"}, 64'(got[i].n), 64'(expq[i].n));
    end
  endtask

  initial begin
    vec_t tbl[8];
    int   e0, ne;
    byte  q[$];
    string pool;

    tbl[0] = '{"1234ABCD",     1, 32'h1234ABCD, 8, 32'h0, 0, 0};
    tbl[1] = '{"ff\n",         1, 32'h000000FF, 2, 32'h0, 0, 0};
    tbl[2] = '{"dead_beef ",   1, 32'hDEADBEEF, 8, 32'h0, 0, 0};
    tbl[3] = '{"12G5 ",        1, 32'h00000005, 1, 32'h0, 0, 1};
    tbl[4] = '{"123456789\n",  2, 32'h12345678, 8, 32'h9, 1, 0};
    tbl[5] = '{",, \015\n",    0, 32'h0,        0, 32'h0, 0, 0};
    tbl[6] = '{"a\tB,",        2, 32'h0000000A, 1, 32'hB, 1, 0};
    tbl[7] = '{"0_0_1 #",      1, 32'h00000001, 3, 32'h0, 0, 1};

    rst = 1'b1; char_valid = 1'b0; char_data = 8'h0;
    rnd_ready = 1'b0; ready_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_char_ready", 64'(char_ready), 64'd0);
    chk("rst_word_valid", 64'(word_valid), 64'd0);
    chk("rst_word_data",  64'(word_data), 64'd0);
    chk("rst_ndigits",    64'(word_ndigits), 64'd0);
    chk("rst_err",        64'(err), 64'd0);
    chk("rst_err_count",  64'(err_count), 64'd0);
    rst = 1'b0;

    // latency: word valid the cycle after the completing digit
    got.delete();
    send_str("1234ABC");
    chk("lat_before", 64'(word_valid), 64'd0);
    send_char("D");
    chk("lat_valid", 64'(word_valid), 64'd1);
    chk("lat_data",  64'(word_data), 64'h1234ABCD);
    drain();

    // err pulse timing and first count
    send_char("1");
    send_char("G");
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_cnt1",  64'(err_count), 64'd1);
    @(posedge clk); #1;
    chk("err_gone",  64'(err), 64'd0);
    drain();

    for (int v = 0; v < 8; v++) begin
      got.delete();
      expq.delete();
      e0 = err_seen;
      send_str(tbl[v].s);
      drain();
      if (tbl[v].nw > 0) expq.push_back('{tbl[v].d0, tbl[v].n0});
      if (tbl[v].nw > 1) expq.push_back('{tbl[v].d1, tbl[v].n1});
      cmp_words($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_errs", v), 64'(err_seen - e0), 64'(tbl[v].ne));
    end

    // backpressure: word held, chars refused
    got.delete();
    ready_force = 1'b0;
    send_str("9 ");
    chk("bp_valid", 64'(word_valid), 64'd1);
    char_valid = 1'b1;
    char_data  = "A";
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(word_valid), 64'd1);
      chk("bp_hold_data",  64'(word_data), 64'h9);
      chk("bp_hold_ndig",  64'(word_ndigits), 64'd1);
      chk("bp_char_ready", 64'(char_ready), 64'd0);
    end
    char_valid = 1'b0;
    ready_force = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", 64'(word_valid), 64'd0);
    chk("bp_ready_back", 64'(char_ready), 64'd1);
    drain();
    expq.delete();
    expq.push_back('{32'h9, 1});
    cmp_words("bp");

    // reset mid-word and during EMIT
    send_str("AB");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_valid", 64'(word_valid), 64'd0);
    chk("rstmid_data",  64'(word_data), 64'd0);
    chk("rstmid_ndig",  64'(word_ndigits), 64'd0);
    chk("rstmid_ready", 64'(char_ready), 64'd0);
    chk("rstmid_errc",  64'(err_count), 64'd0);
    rst = 1'b0;
    ready_force = 1'b0;
    send_str("3 ");
    chk("rstemit_pre", 64'(word_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstemit_valid", 64'(word_valid), 64'd0);
    chk("rstemit_data",  64'(word_data), 64'd0);
    rst = 1'b0;
    ready_force = 1'b1;
    got.delete();
    send_str("7 ");
    drain();
    expq.delete();
    expq.push_back('{32'h7, 1});
    cmp_words("rst_after");

    // random strings vs model, random word_ready
    pool = "0123456789abcdefABCDEF0123456789 ,__\n\t\015Gz#";
    for (int r = 0; r < 12; r++) begin
      q.delete();
      for (int i = 0; i < 40; i++) q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
      q.push_back(8'h0A);
      model(q, ne);
      got.delete();
      e0 = err_seen;
      rnd_ready = 1'b1;
      send_q(q);
      drain();
      cmp_words($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_errs", r), 64'(err_seen - e0), 64'(ne));
    end

    // saturation of the error counter
    for (int i = 0; i < 300; i++) send_char("#");
    chk("err_sat", 64'(err_count), 64'hFF);
    send_char("z");
    chk("err_sat_hold", 64'(err_count), 64'hFF);

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end
endmodule
